conv_axil_regbank: RTL and testbench
====================================

# conv_axil_regbank

AXI4-Lite control/status register bank for the convolution stream core, replacing the fixed four-register slave. It has a parametrised number of signed kernel coefficients that are double-buffered: software writes a shadow bank, and the active bank driving the convolution datapath changes only at a frame boundary after a commit request. It also exposes read-only status and a frame counter, honours byte write strobes, and returns SLVERR on unmapped addresses.

## Interface
- C_DATA_WIDTH, 32, AXI data width; fixed at 32.
- C_ADDR_WIDTH, 6, AXI address width; must be at least clog2(16 + 4*C_NUM_COEF).
- C_NUM_COEF, 9, number of kernel coefficients (3x3 default); range 1..64.
- C_COEF_WIDTH, 8, coefficient width, two's complement; range 2..32.

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  reset, synchronous, active-low.
- S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  write address channel; AWPROT ignored.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response.
- S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  C_ADDR_WIDTH/3/1/1  read address; ARPROT ignored.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data.
- frame_start  in  1  one-cycle pulse from the video timing, one per frame.
- conv_enable  out  1  CTRL.enable.
- conv_shift  out  4  CTRL.shift, the output right-shift amount.
- coef_active  out  C_NUM_COEF*C_COEF_WIDTH  active bank; coefficient k sits at bits [k*C_COEF_WIDTH +: C_COEF_WIDTH].
- commit_done  out  1  one-cycle pulse when the active bank is updated.

## Operation
- Register map (word addresses, address bits [1:0] ignored):
  - 0x00 CTRL RW: bit0 enable, bit1 commit (write-1 requests a commit, self-clearing, always reads 0), bits[7:4] shift; all other bits read 0.
  - 0x04 STATUS RO: bit0 commit_pending.
  - 0x08 FRAME_COUNT RO: 32-bit count of frame_start pulses seen while enable=1; wraps 0xFFFFFFFF -> 0.
  - 0x0C SCRATCH RW: 32 bits.
  - 0x10 + 4k, k < C_NUM_COEF, COEF[k] RW shadow.
- Coefficient registers:
  - Each stores the low C_COEF_WIDTH bits.
  - Reads return the shadow value sign-extended to 32 bits.
  - A byte lane updates only when its WSTRB bit is 1; this applies to every RW register.
- Writes to RO registers have no effect and return BRESP OKAY. Unmapped writes have no effect and return SLVERR. Unmapped reads return RDATA 0 and RRESP SLVERR.
- Commit sequence:
  - A write with CTRL.commit=1 sets commit_pending.
  - On a later frame_start with commit_pending=1, all shadows are copied to the active bank, commit_pending clears, and commit_done pulses.
  - A commit request in the same cycle as frame_start leaves pending=1 and commits at the next frame_start.
  - A COEF write in the commit cycle: the active bank takes the pre-write shadow, and the shadow takes the new value.
- Repeated commit requests while pending have no additional effect.

## Timing
- Reset values: AWREADY, WREADY, ARREADY, BVALID and RVALID are 0; BRESP, RRESP and RDATA are 0. CTRL, SCRATCH, FRAME_COUNT, every shadow, the active bank, commit_pending and commit_done are all 0.
- Write path:
  - AWREADY and WREADY assert together for exactly one cycle (cycle T) when AWVALID=1, WVALID=1 and BVALID=0. The AW and W handshakes always complete in the same cycle.
  - The register value is visible from T+1, and BVALID rises at T+1.
  - BVALID holds with a stable BRESP until BREADY=1. A new write is not accepted while BVALID=1.
- Read path:
  - ARREADY asserts for one cycle (T) when ARVALID=1 and RVALID=0.
  - RDATA is sampled at T and presented with RVALID at T+1. RVALID, RDATA and RRESP are held stable until RREADY=1.
- Read and write paths are independent. A read and a write to the same address accepted in the same cycle: the read returns the old value.
- CTRL outputs (conv_enable, conv_shift) change at T+1 after the write handshake.
- commit_done pulses in the cycle after the committing frame_start, aligned with the coef_active update.
- ARESETN low in any cycle aborts all pending responses: BVALID and RVALID drop to 0 at the next edge.

## Test plan
- Reset, then read 0x00, 0x04, 0x08, 0x0C and 0x10 -> each returns 0 with OKAY; coef_active=0.
- Write COEF[4]=0x000000FF then read it back -> RDATA 0xFFFFFFFF; coef_active unchanged. Write CTRL=0x3, pulse frame_start -> STATUS=1 before the pulse. One cycle after the pulse: commit_done=1, coef_active[39:32]=0xFF, STATUS=0.
- Write SCRATCH=0xA5A5A5A5, then write 0x12345678 with WSTRB=0b0100 -> read returns 0xA534A5A5.
- Write and read address 0x3C (unmapped at defaults) -> BRESP=SLVERR; RDATA=0 with RRESP=SLVERR.
- Hold BREADY=0 and RREADY=0 for 5 cycles:
  - BVALID, RVALID and RDATA stay stable throughout.
  - A second AWVALID/WVALID pair is not accepted until BREADY=1.
- Set enable=1 and pulse frame_start three times, then clear enable and pulse once more -> FRAME_COUNT=3. Assert commit in the same cycle as frame_start -> no commit until the following frame_start.

Source files
------------

// File: rtl/conv_axil_regbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// conv_axil_regbank: AXI4-Lite CSR bank with double-buffered conv coefficients
// Revision: 1.0
// ----------------------------------------------------------------------------
module conv_axil_regbank #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_COEF   = 9,
  parameter int C_COEF_WIDTH = 8
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_AWADDR,
  input  logic [2:0]                           S_AXI_AWPROT,
  input  logic                                 S_AXI_AWVALID,
  output logic                                 S_AXI_AWREADY,
  input  logic [C_DATA_WIDTH-1:0]              S_AXI_WDATA,
  input  logic [C_DATA_WIDTH/8-1:0]            S_AXI_WSTRB,
  input  logic                                 S_AXI_WVALID,
  output logic                                 S_AXI_WREADY,
  output logic [1:0]                           S_AXI_BRESP,
  output logic                                 S_AXI_BVALID,
  input  logic                                 S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]              S_AXI_ARADDR,
  input  logic [2:0]                           S_AXI_ARPROT,
  input  logic                                 S_AXI_ARVALID,
  output logic                                 S_AXI_ARREADY,
  output logic [C_DATA_WIDTH-1:0]              S_AXI_RDATA,
  output logic [1:0]                           S_AXI_RRESP,
  output logic                                 S_AXI_RVALID,
  input  logic                                 S_AXI_RREADY,
  input  logic                                 frame_start,
  output logic                                 conv_enable,
  output logic [3:0]                           conv_shift,
  output logic [C_NUM_COEF*C_COEF_WIDTH-1:0]   coef_active,
  output logic                                 commit_done
);

  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam int         C_COEF_BASE   = 4;

  typedef logic [C_COEF_WIDTH-1:0] coef_t;

  function automatic logic [C_DATA_WIDTH-1:0] strobe_merge(
    input logic [C_DATA_WIDTH-1:0]   old_v,
    input logic [C_DATA_WIDTH-1:0]   new_v,
    input logic [C_DATA_WIDTH/8-1:0] strb
  );
    logic [C_DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < C_DATA_WIDTH/8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic                    ctrl_enable_q, ctrl_enable_d;
  logic [3:0]              ctrl_shift_q, ctrl_shift_d;
  logic [31:0]             scratch_q, scratch_d;
  logic [31:0]             frame_cnt_q, frame_cnt_d;
  logic                    pending_q, pending_d;
  logic                    commit_done_q, commit_done_d;
  coef_t                   shadow_q [C_NUM_COEF];
  coef_t                   shadow_d [C_NUM_COEF];
  coef_t                   active_q [C_NUM_COEF];
  coef_t                   active_d [C_NUM_COEF];
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    rvalid_q, rvalid_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    w_wr_en, w_rd_en, w_commit_req, w_commit_fire;
  logic                    w_wr_err, w_rd_err;
  logic [31:0]             w_wr_word, w_rd_word, w_rd_data, w_merged;
  logic                    w_unused;

  assign w_wr_word = {{(34-C_ADDR_WIDTH){1'b0}}, S_AXI_AWADDR[C_ADDR_WIDTH-1:2]};
  assign w_rd_word = {{(34-C_ADDR_WIDTH){1'b0}}, S_AXI_ARADDR[C_ADDR_WIDTH-1:2]};
  assign w_wr_en   = ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
  assign w_rd_en   = ARESETN & S_AXI_ARVALID & ~rvalid_q;
  assign w_unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_word == 32'd0)      w_rd_data = {24'd0, ctrl_shift_q, 3'b000, ctrl_enable_q};
    else if (w_rd_word == 32'd1) w_rd_data = {31'd0, pending_q};
    else if (w_rd_word == 32'd2) w_rd_data = frame_cnt_q;
    else if (w_rd_word == 32'd3) w_rd_data = scratch_q;
    else begin
      w_rd_err = 1'b1;
      for (int k = 0; k < C_NUM_COEF; k++) begin
        if (w_rd_word == 32'(C_COEF_BASE + k)) begin
          w_rd_data = 32'($signed(shadow_q[k]));
          w_rd_err  = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ctrl_enable_d = ctrl_enable_q;
    ctrl_shift_d  = ctrl_shift_q;
    scratch_d     = scratch_q;
    frame_cnt_d   = frame_cnt_q;
    pending_d     = pending_q;
    commit_done_d = 1'b0;
    shadow_d      = shadow_q;
    active_d      = active_q;
    bvalid_d      = bvalid_q;
    bresp_d       = bresp_q;
    rvalid_d      = rvalid_q;
    rresp_d       = rresp_q;
    rdata_d       = rdata_q;
    w_commit_req  = 1'b0;
    w_wr_err      = 1'b0;
    w_merged      = '0;

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;
    if (w_wr_en) begin
      if (w_wr_word == 32'd0) begin
        if (S_AXI_WSTRB[0]) begin
          ctrl_enable_d = S_AXI_WDATA[0];
          ctrl_shift_d  = S_AXI_WDATA[7:4];
          w_commit_req  = S_AXI_WDATA[1];
        end
      end else if (w_wr_word == 32'd1 || w_wr_word == 32'd2) begin
        w_wr_err = 1'b0;
      end else if (w_wr_word == 32'd3) begin
        scratch_d = strobe_merge(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);
      end else begin
        w_wr_err = 1'b1;
        for (int k = 0; k < C_NUM_COEF; k++) begin
          if (w_wr_word == 32'(C_COEF_BASE + k)) begin
            w_merged    = strobe_merge(32'(shadow_q[k]), S_AXI_WDATA, S_AXI_WSTRB);
            shadow_d[k] = w_merged[C_COEF_WIDTH-1:0];
            w_wr_err    = 1'b0;
          end
        end
      end
      bvalid_d = 1'b1;
      bresp_d  = w_wr_err ? C_RESP_SLVERR : C_RESP_OKAY;
    end

    if (frame_start && ctrl_enable_q) frame_cnt_d = frame_cnt_q + 32'd1;
    // Active bank copies the pre-write shadow; a fresh request re-arms pending.
    w_commit_fire = frame_start & pending_q;
    if (w_commit_fire) begin
      active_d      = shadow_q;
      commit_done_d = 1'b1;
      pending_d     = 1'b0;
    end
    if (w_commit_req) pending_d = 1'b1;

    if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
    if (w_rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = w_rd_data;
      rresp_d  = w_rd_err ? C_RESP_SLVERR : C_RESP_OKAY;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ctrl_enable_q <= 1'b0;
      ctrl_shift_q  <= '0;
      scratch_q     <= '0;
      frame_cnt_q   <= '0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      for (int k = 0; k < C_NUM_COEF; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      bvalid_q      <= 1'b0;
      bresp_q       <= '0;
      rvalid_q      <= 1'b0;
      rresp_q       <= '0;
      rdata_q       <= '0;
    end else begin
      ctrl_enable_q <= ctrl_enable_d;
      ctrl_shift_q  <= ctrl_shift_d;
      scratch_q     <= scratch_d;
      frame_cnt_q   <= frame_cnt_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      bvalid_q      <= bvalid_d;
      bresp_q       <= bresp_d;
      rvalid_q      <= rvalid_d;
      rresp_q       <= rresp_d;
      rdata_q       <= rdata_d;
    end
  end

  generate
    for (genvar k = 0; k < C_NUM_COEF; k++) begin : g_pack
      assign coef_active[k*C_COEF_WIDTH +: C_COEF_WIDTH] = active_q[k];
    end
  endgenerate

  assign S_AXI_AWREADY = w_wr_en;
  assign S_AXI_WREADY  = w_wr_en;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = w_rd_en;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign conv_enable   = ctrl_enable_q;
  assign conv_shift    = ctrl_shift_q;
  assign commit_done   = commit_done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_axil_regbank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_conv_axil_regbank: randomized self-checking bench with a register-map model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_conv_axil_regbank;
  localparam int AW = 6;
  localparam int N  = 9;
  localparam int CW = 8;

  logic ACLK = 1'b0;
  logic ARESETN;
  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0]   S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RVALID, S_AXI_RREADY;
  logic          frame_start, conv_enable, commit_done;
  logic [3:0]    conv_shift;
  logic [N*CW-1:0] coef_active;

  always #5 ACLK = ~ACLK;

  conv_axil_regbank #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(AW), .C_NUM_COEF(N), .C_COEF_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
    .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR),
    .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY), .frame_start(frame_start), .conv_enable(conv_enable),
    .conv_shift(conv_shift), .coef_active(coef_active), .commit_done(commit_done)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the register map
  logic [7:0]  m_shadow [N];
  logic [7:0]  m_active [N];
  logic        m_enable, m_pending, exp_commit;
  logic [3:0]  m_shift;
  logic [31:0] m_scratch, m_fcnt;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin m_shadow[k] = '0; m_active[k] = '0; end
    m_enable = 0; m_pending = 0; exp_commit = 0; m_shift = 0; m_scratch = 0; m_fcnt = 0;
  endtask

  task automatic model_frame();
    exp_commit = 0;
    if (m_enable) m_fcnt = m_fcnt + 1;
    if (m_pending) begin
      for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
      m_pending = 0;
      exp_commit = 1;
    end
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    int w;
    w = int'(a) / 4;
    r = 2'b00;
    if (w == 0) begin
      if (s[0]) begin m_enable = d[0]; m_shift = d[7:4]; if (d[1]) m_pending = 1; end
    end else if (w == 1 || w == 2) begin
      r = 2'b00;
    end else if (w == 3) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_scratch[8*b +: 8] = d[8*b +: 8];
    end else if (w < 4 + N) begin
      if (s[0]) m_shadow[w-4] = d[7:0];
    end else begin
      r = 2'b10;
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [34:0] e);
    int w, v;
    w = int'(a) / 4;
    case (w)
      0: e = {1'b1, 2'b00, 24'd0, m_shift, 3'b000, m_enable};
      1: e = {1'b1, 2'b00, 31'd0, m_pending};
      2: e = {1'b1, 2'b00, m_fcnt};
      3: e = {1'b1, 2'b00, m_scratch};
      default: begin
        if (w < 4 + N) begin
          v = int'(m_shadow[w-4]);
          if (v > 127) v = v - 256;
          e = {1'b1, 2'b00, 32'(v)};
        end else e = {1'b1, 2'b10, 32'd0};
      end
    endcase
  endtask

  function automatic logic [N*CW-1:0] exp_active();
    logic [N*CW-1:0] r;
    for (int k = 0; k < N; k++) r[k*CW +: CW] = m_active[k];
    return r;
  endfunction

  // Write with optional frame_start in the handshake cycle; returns {BVALID,BRESP} at T+1
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit fs, output logic [2:0] gb, output logic [2:0] eb,
                           output logic cd);
    bit got;
    logic [1:0] r;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1; frame_start = fs;
    if (!fs) exp_commit = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK); got = S_AXI_AWREADY && S_AXI_WREADY;
      @(posedge ACLK); #1;
      if (i == 0 && fs) model_frame();
      frame_start = 0;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    cd = commit_done;
    gb = {S_AXI_BVALID, S_AXI_BRESP};
    eb = 3'b100;
    if (!got) begin
      checks++; errors++;
      $display("FAIL aw_timeout addr %h got no handshake required handshake", a);
    end else begin
      model_write(a, d, s, r);
      eb = {1'b1, r};
    end
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [34:0] g, output logic [34:0] e);
    bit got;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge ACLK); got = S_AXI_ARREADY;
      @(posedge ACLK); #1;
    end
    S_AXI_ARVALID = 0;
    model_read(a, e);
    g = {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA};
    if (!got) begin
      checks++; errors++;
      $display("FAIL ar_timeout addr %h got no handshake required handshake", a);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_frame(output logic cd);
    frame_start = 1;
    @(posedge ACLK); #1;
    frame_start = 0;
    model_frame();
    cd = commit_done;
  endtask

  task automatic test_reset();
    logic [34:0] g, e;
    logic [5:0] addrs [5];
    addrs = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
    ARESETN = 0;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
    repeat (3) begin
      @(posedge ACLK); #1;
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID} !== 5'b0) begin
        errors++;
        $display("FAIL reset_handshake got %b required 00000",
                 {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID});
      end
    end
    checks++;
    if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, coef_active, commit_done, conv_enable, conv_shift} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdata %h coef %h cd %b en %b sh %h required zero",
               S_AXI_RDATA, coef_active, commit_done, conv_enable, conv_shift);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    ARESETN = 1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      axi_read(addrs[i], g, e);
      checks++;
      if (g !== {1'b1, 2'b00, 32'd0}) begin
        errors++; $display("FAIL reset_read addr %h got %h required %h", addrs[i], g, {1'b1, 2'b00, 32'd0});
      end
    end
  endtask

  task automatic test_coef_commit();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    axi_write(6'h20, 32'h0000_00FF, 4'hF, 0, gb, eb, cd);
    axi_read(6'h20, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'hFFFF_FFFF} || g !== e) begin
      errors++; $display("FAIL coef_sext got %h required %h", g, {1'b1, 2'b00, 32'hFFFF_FFFF});
    end
    checks++;
    if (coef_active !== '0) begin errors++; $display("FAIL coef_pre_commit got %h required 0", coef_active); end
    axi_write(6'h00, 32'h3, 4'hF, 0, gb, eb, cd);
    axi_read(6'h04, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'd1}) begin errors++; $display("FAIL status_pending got %h required %h", g, e); end
    pulse_frame(cd);
    checks++;
    if (cd !== 1'b1 || coef_active[39:32] !== 8'hFF || coef_active !== exp_active()) begin
      errors++; $display("FAIL commit_apply got cd %b coef %h required cd 1 coef %h", cd, coef_active, exp_active());
    end
    @(posedge ACLK); #1;
    checks++;
    if (commit_done !== 1'b0) begin errors++; $display("FAIL commit_done_width got %b required 0", commit_done); end
    axi_read(6'h04, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'd0}) begin errors++; $display("FAIL status_cleared got %h required %h", g, e); end
  endtask

  task automatic test_strobe();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    axi_write(6'h0C, 32'hA5A5_A5A5, 4'hF, 0, gb, eb, cd);
    axi_write(6'h0C, 32'h1234_5678, 4'b0100, 0, gb, eb, cd);
    axi_read(6'h0C, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'hA534_A5A5} || g !== e) begin
      errors++; $display("FAIL scratch_strobe got %h required %h", g, {1'b1, 2'b00, 32'hA534_A5A5});
    end
    axi_write(6'h24, 32'h0000_0080, 4'b1110, 0, gb, eb, cd);
    axi_read(6'h24, g, e);
    checks++;
    if (g !== e) begin errors++; $display("FAIL coef_strobe_masked got %h required %h", g, e); end
  endtask

  task automatic test_unmapped();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    logic [5:0] addrs [4];
    addrs = '{6'h3C, 6'h34, 6'h30, 6'h04};
    for (int i = 0; i < 4; i++) begin
      axi_write(addrs[i], 32'h5A5A_0001, 4'hF, 0, gb, eb, cd);
      checks++;
      if (gb !== eb) begin errors++; $display("FAIL map_bresp addr %h got %h required %h", addrs[i], gb, eb); end
      axi_read(addrs[i], g, e);
      checks++;
      if (g !== e) begin errors++; $display("FAIL map_read addr %h got %h required %h", addrs[i], g, e); end
    end
    checks++;
    if (eb[1:0] !== 2'b00 || e !== {1'b1, 2'b00, 31'd0, m_pending}) begin
      errors++; $display("FAIL status_ro got %h required OKAY and pending", e);
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] e_old, g, e;
    logic [1:0] r1, r2;
    logic [31:0] d1, d2;
    bit got;
    d1 = $urandom; d2 = $urandom;
    model_read(6'h0C, e_old);
    S_AXI_AWADDR = 6'h0C; S_AXI_WDATA = d1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 6'h0C; S_AXI_ARVALID = 1; S_AXI_RREADY = 0;
    @(negedge ACLK);
    checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      errors++; $display("FAIL bp_accept got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge ACLK); #1;
    S_AXI_ARVALID = 0; S_AXI_WDATA = d2;
    model_write(6'h0C, d1, 4'hF, r1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP} !== {1'b1, r1}) begin
        errors++; $display("FAIL bp_bhold cyc %0d got %b required %b", i, {S_AXI_BVALID, S_AXI_BRESP}, {1'b1, r1});
      end
      checks++;
      if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== e_old) begin
        errors++; $display("FAIL bp_rhold cyc %0d got %h required %h", i, {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, e_old);
      end
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b00) begin
        errors++; $display("FAIL bp_blocked cyc %0d got %b required 00", i, {S_AXI_AWREADY, S_AXI_WREADY});
      end
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge ACLK); got = S_AXI_AWREADY && S_AXI_WREADY;
      @(posedge ACLK); #1;
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    checks++;
    if (!got) begin
      errors++; $display("FAIL bp_second_write got no handshake required handshake");
    end else begin
      model_write(6'h0C, d2, 4'hF, r2);
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID} !== {1'b1, r2, 1'b0}) begin
        errors++; $display("FAIL bp_release got %b required %b", {S_AXI_BVALID, S_AXI_BRESP, S_AXI_RVALID}, {1'b1, r2, 1'b0});
      end
    end
    @(posedge ACLK); #1;
    axi_read(6'h0C, g, e);
    checks++;
    if (g !== e) begin errors++; $display("FAIL bp_final_scratch got %h required %h", g, e); end
  endtask

  task automatic test_frame_count();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    ARESETN = 0;
    repeat (2) @(posedge ACLK);
    #1; ARESETN = 1;
    model_reset();
    axi_write(6'h00, 32'h0000_00A1, 4'hF, 0, gb, eb, cd);
    checks++;
    if ({conv_enable, conv_shift} !== {m_enable, m_shift} || conv_shift !== 4'hA) begin
      errors++; $display("FAIL ctrl_outputs got %b %h required %b %h", conv_enable, conv_shift, m_enable, m_shift);
    end
    repeat (3) begin pulse_frame(cd); @(posedge ACLK); #1; end
    axi_write(6'h00, 32'h0, 4'hF, 0, gb, eb, cd);
    pulse_frame(cd);
    axi_read(6'h08, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'd3} || g !== e) begin
      errors++; $display("FAIL frame_count got %h required %h", g, {1'b1, 2'b00, 32'd3});
    end
  endtask

  task automatic test_commit_same_cycle();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    axi_write(6'h10, 32'h11, 4'hF, 0, gb, eb, cd);
    axi_write(6'h00, 32'h3, 4'hF, 1, gb, eb, cd);
    checks++;
    if (cd !== 1'b0 || cd !== exp_commit || coef_active !== exp_active()) begin
      errors++; $display("FAIL same_cycle_no_commit got cd %b coef %h required cd 0 coef %h", cd, coef_active, exp_active());
    end
    axi_read(6'h04, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'd1}) begin errors++; $display("FAIL same_cycle_pending got %h required %h", g, e); end
    axi_write(6'h10, 32'h22, 4'hF, 1, gb, eb, cd);
    checks++;
    if (cd !== 1'b1 || coef_active[7:0] !== 8'h11 || coef_active !== exp_active()) begin
      errors++; $display("FAIL commit_cycle_write got cd %b coef %h required cd 1 coef %h", cd, coef_active, exp_active());
    end
    axi_read(6'h10, g, e);
    checks++;
    if (g !== {1'b1, 2'b00, 32'h22}) begin errors++; $display("FAIL commit_cycle_shadow got %h required %h", g, e); end
    axi_write(6'h00, 32'h3, 4'hF, 0, gb, eb, cd);
    axi_write(6'h00, 32'h3, 4'hF, 0, gb, eb, cd);
    pulse_frame(cd);
    @(posedge ACLK); #1;
    pulse_frame(cd);
    checks++;
    if (cd !== 1'b0 || cd !== exp_commit || coef_active[7:0] !== 8'h22) begin
      errors++; $display("FAIL repeat_request got cd %b coef0 %h required cd 0 coef0 22", cd, coef_active[7:0]);
    end
  endtask

  task automatic test_random();
    logic [2:0] gb, eb; logic cd; logic [34:0] g, e;
    logic [AW-1:0] a;
    for (int it = 0; it < 80; it++) begin
      a = AW'($urandom_range(0, 63));
      case ($urandom_range(0, 3))
        0, 1: begin
          axi_write(a, $urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), gb, eb, cd);
          checks++;
          if (gb !== eb || cd !== exp_commit) begin
            errors++; $display("FAIL rnd_write it %0d addr %h got %h cd %b required %h cd %b", it, a, gb, cd, eb, exp_commit);
          end
        end
        2: begin
          axi_read(a, g, e);
          checks++;
          if (g !== e) begin errors++; $display("FAIL rnd_read it %0d addr %h got %h required %h", it, a, g, e); end
        end
        default: begin
          pulse_frame(cd);
          checks++;
          if (cd !== exp_commit) begin errors++; $display("FAIL rnd_frame it %0d got %b required %b", it, cd, exp_commit); end
          @(posedge ACLK); #1;
        end
      endcase
      checks++;
      if (coef_active !== exp_active() || {conv_enable, conv_shift} !== {m_enable, m_shift}) begin
        errors++; $display("FAIL rnd_outputs it %0d got %h %b %h required %h %b %h", it, coef_active,
                           conv_enable, conv_shift, exp_active(), m_enable, m_shift);
      end
    end
  endtask

  initial begin
    ARESETN = 0; frame_start = 0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    model_reset();
    test_reset();
    test_coef_commit();
    test_strobe();
    test_unmapped();
    test_backpressure();
    test_frame_count();
    test_commit_same_cycle();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
